// File: rtl/send_scheduler_pkg.sv
// send_scheduler_pkg: message layout and dispatch states shared by the send scheduler
//   MSG_W   : packed message width
//   msg_t   : {msg_type, block_x, block_y, card, sel_len, move_dir}, msg_type in the MSBs
//   state_t : dispatch FSM states
package send_scheduler_pkg;
    localparam int MSG_W = 22;
    typedef struct packed {
        logic [3:0] msg_type;
        logic [4:0] block_x;
        logic [2:0] block_y;
        logic [5:0] card;
        logic [2:0] sel_len;
        logic       move_dir;
    } msg_t;
    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE, S_GAP} state_t;
endpackage

// File: rtl/send_scheduler_msg_fifo.sv
// msg_fifo: DEPTH-entry message FIFO with show-ahead head
//   clk, rst (async, active-low)
//   push/din  : write an entry (ignored when full)
//   pop/dout  : dout is the current head; pop drops it (ignored when empty)
//   full, empty, count : occupancy status
module msg_fifo import send_scheduler_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  msg_t        din,
    output msg_t        dout,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);
    msg_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/send_scheduler.sv
// send_scheduler: round-robin message arbiter, FIFO and one-at-a-time launcher for the sender
//   clk, rst (async, active-low)
//   req_valid/req_msg/req_grant : NREQ requesters, message i at [22i+:22], grant is a 1-cycle pulse
//   sender_busy                 : sender is transmitting
//   ctrl_en + ctrl_*            : launch pulse and registered head-of-FIFO fields
//   fifo_count, timeout_err     : occupancy and sticky start/done timeout flag
module send_scheduler import send_scheduler_pkg::*; #(
    parameter int NREQ = 2,
    parameter int DEPTH = 4,
    parameter int START_TO = 64,
    parameter int DONE_TO = 2**20,
    parameter int GAP = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*MSG_W-1:0]    req_msg,
    output logic [NREQ-1:0]          req_grant,
    input  logic                     sender_busy,
    output logic                     ctrl_en,
    output logic [3:0]               ctrl_msg_type,
    output logic [4:0]               ctrl_block_x,
    output logic [2:0]               ctrl_block_y,
    output logic [5:0]               ctrl_card,
    output logic [2:0]               ctrl_sel_len,
    output logic                     ctrl_move_dir,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     timeout_err
);
    localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam int TMAX = DONE_TO > START_TO ? DONE_TO : START_TO;
    localparam int CW = $clog2(TMAX) + 1;
    logic [NREQ-1:0] elig, grant_n;
    logic [PW-1:0] rr_ptr, win;
    logic found, room, full, empty, pop, err_n;
    msg_t stage, head, ctrl;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    // A requester still shows valid during its grant cycle; mask it so it is not granted twice.
    // The granted message is staged and pushed one cycle later, so that pending push counts against room.
    always_comb begin
        elig = req_valid & ~req_grant;
        win = '0;
        found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (elig[(int'(rr_ptr) + k) % NREQ]) begin
                win = PW'((int'(rr_ptr) + k) % NREQ);
                found = 1'b1;
            end
        room = !full && (int'(fifo_count) + int'(|req_grant) < DEPTH);
        grant_n = (found && room) ? NREQ'(1) << win : '0;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            req_grant <= '0;
            rr_ptr <= '0;
            stage <= '0;
        end else begin
            req_grant <= grant_n;
            if (|grant_n) begin
                rr_ptr <= PW'((int'(win) + 1) % NREQ);
                stage <= req_msg[int'(win)*MSG_W +: MSG_W];
            end
        end
    msg_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(|req_grant),
        .pop(pop),
        .din(stage),
        .dout(head),
        .full(full),
        .empty(empty),
        .count(fifo_count)
    );
    always_comb begin
        state_n = state;
        pop = 1'b0;
        err_n = 1'b0;
        case (state)
            S_IDLE: state_n = (!empty && !sender_busy) ? S_LAUNCH : S_IDLE;
            S_LAUNCH: state_n = S_WAIT_BUSY;
            S_WAIT_BUSY:
                if (sender_busy) state_n = S_WAIT_DONE;
                else if (cnt == CW'(START_TO - 1)) begin
                    err_n = 1'b1;
                    pop = 1'b1;
                    state_n = S_GAP;
                end
            S_WAIT_DONE:
                if (!sender_busy || cnt == CW'(DONE_TO - 1)) begin
                    err_n = sender_busy;
                    pop = 1'b1;
                    state_n = S_GAP;
                end
            S_GAP: state_n = (cnt == CW'(GAP - 1)) ? S_IDLE : S_GAP;
            default: state_n = S_IDLE;
        endcase
    end
    // One shared saturating counter restarts on every state change except LAUNCH->WAIT_BUSY,
    // so the start timeout is measured from the ctrl_en cycle itself.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= S_IDLE;
            cnt <= '0;
            timeout_err <= 1'b0;
            ctrl <= '0;
        end else begin
            state <= state_n;
            cnt <= (state_n != state && state != S_LAUNCH) ? '0 : (&cnt ? cnt : cnt + CW'(1));
            timeout_err <= timeout_err | err_n;
            if (state == S_IDLE && state_n == S_LAUNCH) ctrl <= head;
        end
    assign ctrl_en = state == S_LAUNCH;
    assign {ctrl_msg_type, ctrl_block_x, ctrl_block_y, ctrl_card, ctrl_sel_len, ctrl_move_dir} = ctrl;
endmodule

// File: tb/tb_send_scheduler.sv
// tb_send_scheduler: directed self-checking bench for send_scheduler
module tb_send_scheduler;
    logic clk, rst, sender_busy, ctrl_en, ctrl_move_dir, timeout_err;
    logic [1:0] req_valid, req_grant;
    logic [43:0] req_msg;
    logic [3:0] ctrl_msg_type;
    logic [4:0] ctrl_block_x;
    logic [2:0] ctrl_block_y, ctrl_sel_len, fifo_count;
    logic [5:0] ctrl_card;
    logic [21:0] ctrl_w;
    int n_cmp = 0, n_err = 0;
    send_scheduler dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_msg(req_msg), .req_grant(req_grant),
        .sender_busy(sender_busy), .ctrl_en(ctrl_en), .ctrl_msg_type(ctrl_msg_type),
        .ctrl_block_x(ctrl_block_x), .ctrl_block_y(ctrl_block_y), .ctrl_card(ctrl_card),
        .ctrl_sel_len(ctrl_sel_len), .ctrl_move_dir(ctrl_move_dir), .fifo_count(fifo_count),
        .timeout_err(timeout_err)
    );
    assign ctrl_w = {ctrl_msg_type, ctrl_block_x, ctrl_block_y, ctrl_card, ctrl_sel_len, ctrl_move_dir};
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [21:0] mk(input int t, input int x, input int y, input int c, input int l, input int d);
        return {t[3:0], x[4:0], y[2:0], c[5:0], l[2:0], d[0]};
    endfunction
    task automatic reset_dut();
        req_valid = '0;
        req_msg = '0;
        sender_busy = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask
    task automatic enqueue(input int i, input logic [21:0] m);
        int n;
        req_msg[i*22 +: 22] = m;
        req_valid[i] = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!req_grant[i] && n < 20);
        check("enq_grant", 32'(req_grant[i]), 1);
        req_valid[i] = 1'b0;
    endtask
    task automatic wait_en(input int max, output int n);
        n = 0;
        while (!ctrl_en && n < max) begin
            tick();
            n++;
        end
        check("en_seen", 32'(ctrl_en), 1);
    endtask
    logic [21:0] m2 [2][2];
    logic [21:0] lord [4];
    int gord [4];
    int sent [2];
    int n, ng, nl, bl;
    logic any;
    initial begin
        // reset state
        req_valid = '0;
        req_msg = '0;
        sender_busy = 1'b0;
        rst = 1'b0;
        tick();
        check("rst_en", 32'(ctrl_en), 0);
        check("rst_grant", 32'(req_grant), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_err", 32'(timeout_err), 0);
        check("rst_ctrl", 32'(ctrl_w), 0);
        // 1: single request latency and fields
        reset_dut();
        req_msg[21:0] = mk(3, 17, 5, 42, 4, 1);
        req_valid = 2'b01;
        tick();
        check("t1_grant", 32'(req_grant), 1);
        check("t1_en_early", 32'(ctrl_en), 0);
        req_valid = 2'b00;
        tick();
        check("t1_grant_pulse", 32'(req_grant), 0);
        check("t1_count", 32'(fifo_count), 1);
        check("t1_en_early2", 32'(ctrl_en), 0);
        tick();
        check("t1_en", 32'(ctrl_en), 1);
        check("t1_fields", 32'(ctrl_w), 32'(mk(3, 17, 5, 42, 4, 1)));
        check("t1_type", 32'(ctrl_msg_type), 3);
        check("t1_card", 32'(ctrl_card), 42);
        tick();
        check("t1_one_pulse", 32'(ctrl_en), 0);
        sender_busy = 1'b1;
        repeat (3) tick();
        sender_busy = 1'b0;
        tick();
        check("t1_pop", 32'(fifo_count), 0);
        check("t1_hold", 32'(ctrl_w), 32'(mk(3, 17, 5, 42, 4, 1)));
        // 2: round-robin alternation and FIFO order
        reset_dut();
        m2[0][0] = mk(1, 1, 1, 1, 1, 0);
        m2[0][1] = mk(2, 2, 2, 2, 2, 1);
        m2[1][0] = mk(5, 9, 3, 11, 6, 1);
        m2[1][1] = mk(7, 30, 7, 63, 7, 0);
        sent = '{0, 0};
        ng = 0;
        nl = 0;
        bl = 0;
        req_msg = {m2[1][0], m2[0][0]};
        req_valid = 2'b11;
        for (int c = 0; c < 200 && nl < 4; c++) begin
            tick();
            if (bl > 0) begin
                bl--;
                if (bl == 0) sender_busy = 1'b0;
            end
            for (int i = 0; i < 2; i++)
                if (req_grant[i]) begin
                    if (ng < 4) gord[ng] = i;
                    ng++;
                    sent[i]++;
                    if (sent[i] < 2) req_msg[i*22 +: 22] = m2[i][sent[i]];
                    else req_valid[i] = 1'b0;
                end
            if (ctrl_en) begin
                if (nl < 4) lord[nl] = ctrl_w;
                nl++;
                sender_busy = 1'b1;
                bl = 3;
            end
        end
        check("t2_ngrant", ng, 4);
        check("t2_nlaunch", nl, 4);
        check("t2_g0", gord[0], 0);
        check("t2_g1", gord[1], 1);
        check("t2_g2", gord[2], 0);
        check("t2_g3", gord[3], 1);
        check("t2_l0", 32'(lord[0]), 32'(m2[0][0]));
        check("t2_l1", 32'(lord[1]), 32'(m2[1][0]));
        check("t2_l2", 32'(lord[2]), 32'(m2[0][1]));
        check("t2_l3", 32'(lord[3]), 32'(m2[1][1]));
        // 3: fill to DEPTH while sender busy, grant resumes after pop
        reset_dut();
        enqueue(0, mk(4, 4, 4, 4, 4, 0));
        wait_en(10, n);
        sender_busy = 1'b1;
        req_msg = {mk(9, 1, 2, 3, 4, 1), mk(10, 5, 6, 7, 1, 0)};
        req_valid = 2'b11;
        repeat (12) tick();
        check("t3_full", 32'(fifo_count), 4);
        any = 1'b0;
        repeat (5) begin
            tick();
            any |= |req_grant;
        end
        check("t3_no_grant_full", 32'(any), 0);
        check("t3_still_full", 32'(fifo_count), 4);
        sender_busy = 1'b0;
        tick();
        check("t3_pop", 32'(fifo_count), 3);
        check("t3_no_grant_pop", 32'(req_grant), 0);
        tick();
        check("t3_grant_resume", 32'(|req_grant), 1);
        tick();
        check("t3_refill", 32'(fifo_count), 4);
        // 4: start timeout
        reset_dut();
        enqueue(0, mk(6, 20, 1, 33, 2, 1));
        enqueue(1, mk(11, 3, 6, 17, 5, 0));
        wait_en(10, n);
        check("t4_first", 32'(ctrl_w), 32'(mk(6, 20, 1, 33, 2, 1)));
        repeat (63) tick();
        check("t4_err_early", 32'(timeout_err), 0);
        check("t4_count_pre", 32'(fifo_count), 2);
        tick();
        check("t4_err", 32'(timeout_err), 1);
        check("t4_popped", 32'(fifo_count), 1);
        wait_en(20, n);
        check("t4_relaunch_gap", n, 5);
        check("t4_second", 32'(ctrl_w), 32'(mk(11, 3, 6, 17, 5, 0)));
        check("t4_err_sticky", 32'(timeout_err), 1);
        // 5: async reset during WAIT_DONE with three queued
        reset_dut();
        enqueue(0, mk(1, 2, 3, 4, 5, 1));
        enqueue(1, mk(2, 3, 4, 5, 6, 0));
        enqueue(0, mk(3, 4, 5, 6, 7, 1));
        sender_busy = 1'b1;
        repeat (3) tick();
        check("t5_count_pre", 32'(fifo_count), 3);
        check("t5_ctrl_pre", 32'(ctrl_w), 32'(mk(1, 2, 3, 4, 5, 1)));
        rst = 1'b0;
        #1;
        check("t5_count", 32'(fifo_count), 0);
        check("t5_ctrl", 32'(ctrl_w), 0);
        check("t5_en", 32'(ctrl_en), 0);
        check("t5_grant", 32'(req_grant), 0);
        sender_busy = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        any = 1'b0;
        repeat (20) begin
            tick();
            any |= ctrl_en;
        end
        check("t5_no_en", 32'(any), 0);
        // 6: back-to-back spacing after busy falls
        reset_dut();
        enqueue(0, mk(12, 7, 2, 50, 3, 1));
        enqueue(1, mk(13, 8, 1, 51, 2, 0));
        wait_en(10, n);
        check("t6_first", 32'(ctrl_w), 32'(mk(12, 7, 2, 50, 3, 1)));
        sender_busy = 1'b1;
        repeat (10) tick();
        sender_busy = 1'b0;
        wait_en(20, n);
        check("t6_spacing", n, 6);
        check("t6_second", 32'(ctrl_w), 32'(mk(13, 8, 1, 51, 2, 0)));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
